page_walker: RTL
================

Name: page_walker

Overview:
- Paging translation unit for the w80386dx core.
- Consumes PG and the page-directory base from the control-register block.
- Translates linear to physical addresses with a two-level 386 page walk over a memory-read handshake.
- On a page fault, writes the faulting linear address into CR2 through the control-register write port.

Parameters:
TLB_ENTRIES, 4, number of TLB entries; power of two, 2..16; used only when PAGE_WALKER_TLB_EN is defined.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high
pg_enable  input  1  CR0.PG
page_directory_base  input  20  CR3[31:12]
cr3_write  input  1  one-cycle pulse on any CR3 load; flush
req_valid  input  1  translation request
req_ready  output  1  request accepted when req_valid & req_ready
req_linear  input  32  linear address
req_write  input  1  1 = write access
req_user  input  1  1 = CPL 3 access
rsp_valid  output  1  one-cycle result pulse; no backpressure
rsp_physical  output  32  physical address; valid only when rsp_fault=0
rsp_fault  output  1  page fault
rsp_error_code  output  3  {U/S, W/R, P}, pushed by the fault handler
mem_rd_valid  output  1  table-entry read request
mem_rd_ready  input  1  read address accepted
mem_rd_addr  output  32  dword-aligned entry address
mem_rd_data_valid  input  1  read data return, one per request
mem_rd_data  input  32  table entry
cr_write_enable  output  1  to control-register write_enable
cr_write_index  output  3  fixed 3'd2 (CR2)
cr_write_data  output  32  faulting linear address

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_fault=0, rsp_physical=0, rsp_error_code=0, mem_rd_valid=0, mem_rd_addr=0, cr_write_enable=0, cr_write_data=0. FSM=IDLE.
- FSM states: IDLE, PDE_REQ, PDE_WAIT, PTE_REQ, PTE_WAIT, RESP.
- req_ready=1 only in IDLE.
- On accept, latch linear, write, user and page_directory_base. A later CR3 change does not affect an in-flight walk.
- Accept with pg_enable=0: go to RESP. Next cycle, rsp_valid=1 with rsp_physical=req_linear and rsp_fault=0.
- Accept with pg_enable=1: go to PDE_REQ.
- PDE_REQ: mem_rd_valid=1, mem_rd_addr={base, lin[31:22], 2'b00}. Hold until mem_rd_ready, then go to PDE_WAIT.
- PDE_WAIT: on mem_rd_data_valid, latch the PDE.
  - If PDE.P (bit0)=0: fault with error code P=0.
  - Otherwise go to PTE_REQ.
- PTE_REQ: mem_rd_addr={PDE[31:12], lin[21:12], 2'b00}; same handshake as PDE_REQ, then PTE_WAIT.
- PTE_WAIT: on data valid, check PTE.P.
  - PTE.P=0: fault with P=0.
  - Otherwise check rights: effective U = PDE.U/S & PTE.U/S; effective W = PDE.R/W & PTE.R/W.
  - Protection fault (P=1) if user & !U, or user & write & !W. Supervisor accesses ignore R/W.
  - No fault: rsp_physical={PTE[31:12], lin[11:0]}.
- RESP: rsp_valid=1 for one cycle, then IDLE.
  - Minimum PG=1 latency, accept to rsp_valid: 5 cycles with zero-wait memory.
- Fault response: rsp_fault=1, rsp_error_code={user, write, P}. In the same cycle, cr_write_enable=1, cr_write_index=2, cr_write_data=linear. Single pulse.
- Accessed/Dirty bit updates are not performed by this block.
- mem_rd_data_valid outside a WAIT state is ignored.
- Reset mid-walk: return to IDLE immediately. The memory interface is reset by the same reset, so no stale return arrives.
- pg_enable dropping mid-walk: the walk completes normally. It affects only subsequent accepts.

Optional Feature:
- PAGE_WALKER_TLB_EN defined:
  - TLB_ENTRIES fully-associative entries: tag lin[31:12], frame[19:0], effective U, effective W, valid bit.
  - Lookup on accept when pg_enable=1.
  - Hit with rights OK: go to RESP, rsp_valid next cycle with no memory reads.
  - Hit with rights failure: protection fault, P=1, next cycle.
  - Miss: normal walk. Successful walks fill the TLB with round-robin replacement.
  - Faulting walks are never filled.
  - All entries are invalidated on cr3_write, when pg_enable=0, and on reset. A cr3_write in the same cycle as a fill: the flush wins.
- PAGE_WALKER_TLB_EN undefined: every PG=1 request walks. The TLB_ENTRIES parameter is ignored.

Decomposition:
- Shared package paging_pkg:
  - walker state enum
  - entry bit positions: P=0, RW=1, US=2
  - CR2 index constant 3'd2
  - packed error-code struct {us, wr, p}
  - TLB entry struct
- One sub-module, page_tlb: storage, lookup, fill, flush. Instantiated only under PAGE_WALKER_TLB_EN.

Test Plan:
- PG=0, req_linear=32'h1234_5678 -> rsp_valid 1 cycle after accept, rsp_physical=32'h1234_5678, no mem_rd_valid.
- PG=1, base=20'h00010, lin=32'h0040_1ABC, PDE=32'h0002_0007, PTE=32'h0003_0007 -> reads 32'h0001_0004 then 32'h0002_0004; rsp_physical=32'h0003_0ABC, fault=0.
- Same address with PTE=32'h0003_0006 -> rsp_fault=1, error=3'b000 (supervisor read); cr_write_enable pulse, index 2, data=32'h0040_1ABC.
- User write with PDE=32'h0002_0007, PTE=32'h0003_0005 -> fault, error=3'b111. The same access as supervisor -> no fault.
- mem_rd_ready held low 3 cycles, and cr3_write pulsed mid-walk -> address held stable, walk uses the latched base; reset asserted mid PTE_WAIT -> all outputs at reset values next edge.
- TLB_EN: repeat the translation from the second scenario -> hit, rsp 1 cycle after accept, no memory reads; after cr3_write -> miss, walk again.

Source files
------------

// File: rtl/paging_pkg.sv
// rtl/paging_pkg.sv - Shared walker state, page-entry bit positions, error-code and TLB entry types.
package paging_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PDE_REQ,
    PDE_WAIT,
    PTE_REQ,
    PTE_WAIT,
    RESP
  } walker_state_e;

  localparam int PTE_P  = 0;
  localparam int PTE_RW = 1;
  localparam int PTE_US = 2;

  localparam logic [2:0] CR2_INDEX = 3'd2;

  typedef struct packed {
    logic us;
    logic wr;
    logic p;
  } err_code_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] tag;
    logic [19:0] frame;
    logic        u;
    logic        w;
  } tlb_entry_t;

  // Supervisor accesses ignore U/S and R/W; user accesses need U, and W when writing.
  function automatic logic prot_fault(input logic user, input logic write,
                                      input logic eff_u, input logic eff_w);
    return user & (~eff_u | (write & ~eff_w));
  endfunction

endpackage

// File: rtl/page_tlb.sv
// rtl/page_tlb.sv - Fully-associative translation cache with round-robin fill and global flush.
module page_tlb
  import paging_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [19:0] lookup_tag_i,
  output logic        hit_o,
  output logic [19:0] hit_frame_o,
  output logic        hit_u_o,
  output logic        hit_w_o,
  input  logic        fill_i,
  input  tlb_entry_t  fill_entry_i
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  tlb_entry_t       entry_q [ENTRIES];
  logic [IDX_W-1:0] rr_q;

  // A flush in the same cycle as a fill discards the fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      rr_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i].valid <= 1'b0;
      end
    end else if (fill_i) begin
      entry_q[rr_q] <= fill_entry_i;
      rr_q          <= rr_q + 1'b1;
    end
  end

  always_comb begin
    hit_o       = 1'b0;
    hit_frame_o = '0;
    hit_u_o     = 1'b0;
    hit_w_o     = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry_q[i].valid && (entry_q[i].tag == lookup_tag_i)) begin
        hit_o       = 1'b1;
        hit_frame_o = entry_q[i].frame;
        hit_u_o     = entry_q[i].u;
        hit_w_o     = entry_q[i].w;
      end
    end
  end

endmodule

// File: rtl/page_walker.sv
// rtl/page_walker.sv - Two-level 386 page walk with CR2 fault write; optional TLB under PAGE_WALKER_TLB_EN.
module page_walker
  import paging_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pg_enable,
  input  logic [19:0] page_directory_base,
  input  logic        cr3_write,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_linear,
  input  logic        req_write,
  input  logic        req_user,
  output logic        rsp_valid,
  output logic [31:0] rsp_physical,
  output logic        rsp_fault,
  output logic [2:0]  rsp_error_code,
  output logic        mem_rd_valid,
  input  logic        mem_rd_ready,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_data_valid,
  input  logic [31:0] mem_rd_data,
  output logic        cr_write_enable,
  output logic [2:0]  cr_write_index,
  output logic [31:0] cr_write_data
);

  walker_state_e state_q, state_d;
  logic          req_ready_q;
  logic [31:0]   lin_q, lin_d;
  logic          write_q, write_d;
  logic          user_q, user_d;
  logic [19:0]   base_q, base_d;
  logic [19:0]   pde_frame_q, pde_frame_d;
  logic          pde_u_q, pde_u_d;
  logic          pde_w_q, pde_w_d;
  logic [31:0]   phys_q, phys_d;
  logic          fault_q, fault_d;
  err_code_t     err_q, err_d;

  logic          accept;
  logic          fill;
  logic          eff_u, eff_w;
  logic          tlb_hit, tlb_u, tlb_w;
  logic [19:0]   tlb_frame;
  tlb_entry_t    fill_entry;
  logic          unused_entry_bits;

  assign accept            = req_valid & req_ready_q;
  assign eff_u             = pde_u_q & mem_rd_data[PTE_US];
  assign eff_w             = pde_w_q & mem_rd_data[PTE_RW];
  assign fill_entry        = '{valid: 1'b1, tag: lin_q[31:12], frame: mem_rd_data[31:12],
                               u: eff_u, w: eff_w};
  assign unused_entry_bits = ^mem_rd_data[11:3];

`ifdef PAGE_WALKER_TLB_EN
  page_tlb #(
    .ENTRIES(TLB_ENTRIES)
  ) u_tlb (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (cr3_write | ~pg_enable),
    .lookup_tag_i (req_linear[31:12]),
    .hit_o        (tlb_hit),
    .hit_frame_o  (tlb_frame),
    .hit_u_o      (tlb_u),
    .hit_w_o      (tlb_w),
    .fill_i       (fill),
    .fill_entry_i (fill_entry)
  );
`else
  localparam int unused_tlb_entries = TLB_ENTRIES;
  logic unused_tlb_inputs;
  assign unused_tlb_inputs = ^{cr3_write, fill, fill_entry};
  assign tlb_hit   = 1'b0;
  assign tlb_frame = '0;
  assign tlb_u     = 1'b0;
  assign tlb_w     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lin_d       = lin_q;
    write_d     = write_q;
    user_d      = user_q;
    base_d      = base_q;
    pde_frame_d = pde_frame_q;
    pde_u_d     = pde_u_q;
    pde_w_d     = pde_w_q;
    phys_d      = phys_q;
    fault_d     = fault_q;
    err_d       = err_q;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lin_d   = req_linear;
          write_d = req_write;
          user_d  = req_user;
          base_d  = page_directory_base;
          if (!pg_enable) begin
            phys_d  = req_linear;
            fault_d = 1'b0;
            err_d   = '0;
            state_d = RESP;
          end else if (tlb_hit) begin
            state_d = RESP;
            if (prot_fault(req_user, req_write, tlb_u, tlb_w)) begin
              phys_d  = '0;
              fault_d = 1'b1;
              err_d   = '{us: req_user, wr: req_write, p: 1'b1};
            end else begin
              phys_d  = {tlb_frame, req_linear[11:0]};
              fault_d = 1'b0;
              err_d   = '0;
            end
          end else begin
            state_d = PDE_REQ;
          end
        end
      end
      PDE_REQ: begin
        if (mem_rd_ready) state_d = PDE_WAIT;
      end
      PDE_WAIT: begin
        if (mem_rd_data_valid) begin
          pde_frame_d = mem_rd_data[31:12];
          pde_u_d     = mem_rd_data[PTE_US];
          pde_w_d     = mem_rd_data[PTE_RW];
          if (!mem_rd_data[PTE_P]) begin
            phys_d  = '0;
            fault_d = 1'b1;
            err_d   = '{us: user_q, wr: write_q, p: 1'b0};
            state_d = RESP;
          end else begin
            state_d = PTE_REQ;
          end
        end
      end
      PTE_REQ: begin
        if (mem_rd_ready) state_d = PTE_WAIT;
      end
      PTE_WAIT: begin
        if (mem_rd_data_valid) begin
          state_d = RESP;
          if (!mem_rd_data[PTE_P]) begin
            phys_d  = '0;
            fault_d = 1'b1;
            err_d   = '{us: user_q, wr: write_q, p: 1'b0};
          end else if (prot_fault(user_q, write_q, eff_u, eff_w)) begin
            phys_d  = '0;
            fault_d = 1'b1;
            err_d   = '{us: user_q, wr: write_q, p: 1'b1};
          end else begin
            phys_d  = {mem_rd_data[31:12], lin_q[11:0]};
            fault_d = 1'b0;
            err_d   = '0;
            fill    = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_ready is registered so it stays low while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      lin_q       <= '0;
      write_q     <= 1'b0;
      user_q      <= 1'b0;
      base_q      <= '0;
      pde_frame_q <= '0;
      pde_u_q     <= 1'b0;
      pde_w_q     <= 1'b0;
      phys_q      <= '0;
      fault_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      lin_q       <= lin_d;
      write_q     <= write_d;
      user_q      <= user_d;
      base_q      <= base_d;
      pde_frame_q <= pde_frame_d;
      pde_u_q     <= pde_u_d;
      pde_w_q     <= pde_w_d;
      phys_q      <= phys_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_physical   = phys_q;
  assign rsp_fault      = fault_q;
  assign rsp_error_code = err_q;

  assign mem_rd_valid = (state_q == PDE_REQ) || (state_q == PTE_REQ);

  always_comb begin
    mem_rd_addr = '0;
    case (state_q)
      PDE_REQ: mem_rd_addr = {base_q, lin_q[31:22], 2'b00};
      PTE_REQ: mem_rd_addr = {pde_frame_q, lin_q[21:12], 2'b00};
      default: mem_rd_addr = '0;
    endcase
  end

  assign cr_write_enable = rsp_valid & fault_q;
  assign cr_write_index  = CR2_INDEX;
  assign cr_write_data   = cr_write_enable ? lin_q : '0;

endmodule
